// File: rtl/mem_wr_router_pkg.sv
// Shared constants for the CPU write router: BRAM select codes, the
// duty-table region bit and the controller addresses that are snooped.
package mem_wr_router_pkg;

    typedef enum logic [1:0] {
        BRAM_SELECT_CONTROLLER = 2'd0,
        BRAM_SELECT_MOD        = 2'd1,
        BRAM_SELECT_NORMAL     = 2'd2,
        BRAM_SELECT_STM        = 2'd3
    } bram_sel_t;

    // Controller word-address bit that diverts a write into the duty table
    localparam int ADDR_DUTY_TABLE_REGION_BIT = 13;

    // Controller registers whose writes steer later data writes
    localparam logic [13:0] ADDR_MOD_MEM_WR_SEGMENT = 14'h0020;
    localparam logic [13:0] ADDR_STM_MEM_WR_SEGMENT = 14'h0050;
    localparam logic [13:0] ADDR_STM_MEM_WR_PAGE    = 14'h0058;
    localparam logic [13:0] ADDR_DUTY_TABLE_WR_PAGE = 14'h0060;

    // Bit positions of the one-hot write target carried through the pipeline
    localparam int TGT_CTL    = 0;
    localparam int TGT_DUTY   = 1;
    localparam int TGT_MOD    = 2;
    localparam int TGT_NORMAL = 3;
    localparam int TGT_STM    = 4;
    localparam int TGT_COUNT  = 5;

endpackage

// File: rtl/mem_wr_router.sv
// Two-stage CPU write router. Stage 1 decodes the target and updates the
// snooped segment/page registers; stage 2 forms the full BRAM address from
// those (already updated) registers, so a write issued right after a
// segment/page write lands in the new segment/page.
module mem_wr_router
    import mem_wr_router_pkg::*;
#(
    parameter int STM_PAGE_WIDTH  = 5,
    parameter int DUTY_PAGE_WIDTH = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          WE,
    input  logic [15:0]                   ADDR,
    input  logic [15:0]                   DIN,
    output logic                          CTL_WE,
    output logic [13:0]                   CTL_ADDR,
    output logic [15:0]                   CTL_DOUT,
    output logic                          DUTY_WE,
    output logic [DUTY_PAGE_WIDTH+12:0]   DUTY_ADDR,
    output logic [15:0]                   DUTY_DOUT,
    output logic                          MOD_WE,
    output logic [14:0]                   MOD_ADDR,
    output logic [15:0]                   MOD_DOUT,
    output logic                          NORMAL_WE,
    output logic [13:0]                   NORMAL_ADDR,
    output logic [15:0]                   NORMAL_DOUT,
    output logic                          STM_WE,
    output logic [STM_PAGE_WIDTH+14:0]    STM_ADDR,
    output logic [15:0]                   STM_DOUT,
    output logic                          MOD_SEG,
    output logic                          STM_SEG,
    output logic [STM_PAGE_WIDTH-1:0]     STM_PAGE,
    output logic [DUTY_PAGE_WIDTH-1:0]    DUTY_PAGE
);

    bram_sel_t                  sel_s;
    logic [TGT_COUNT-1:0]       tgt_s;
    logic                       ctl_reg_wr_s;

    logic [TGT_COUNT-1:0]       s1_tgt_r;
    logic [13:0]                s1_addr_r;
    logic [15:0]                s1_din_r;

    logic                       mod_seg_r;
    logic                       stm_seg_r;
    logic [STM_PAGE_WIDTH-1:0]  stm_page_r;
    logic [DUTY_PAGE_WIDTH-1:0] duty_page_r;

    logic                       ctl_we_r;
    logic [13:0]                ctl_addr_r;
    logic [15:0]                ctl_dout_r;
    logic                       duty_we_r;
    logic [DUTY_PAGE_WIDTH+12:0] duty_addr_r;
    logic [15:0]                duty_dout_r;
    logic                       mod_we_r;
    logic [14:0]                mod_addr_r;
    logic [15:0]                mod_dout_r;
    logic                       normal_we_r;
    logic [13:0]                normal_addr_r;
    logic [15:0]                normal_dout_r;
    logic                       stm_we_r;
    logic [STM_PAGE_WIDTH+14:0] stm_addr_r;
    logic [15:0]                stm_dout_r;

    // Decode the incoming write into a one-hot target (all zero when idle)
    always_comb begin
        tgt_s        = '0;
        ctl_reg_wr_s = 1'b0;
        sel_s        = bram_sel_t'(ADDR[15:14]);
        if (WE) begin
            case (sel_s)
                BRAM_SELECT_CONTROLLER: begin
                    if (ADDR[ADDR_DUTY_TABLE_REGION_BIT]) begin
                        tgt_s[TGT_DUTY] = 1'b1;
                    end else begin
                        tgt_s[TGT_CTL] = 1'b1;
                        ctl_reg_wr_s   = 1'b1;
                    end
                end
                BRAM_SELECT_MOD:    tgt_s[TGT_MOD]    = 1'b1;
                BRAM_SELECT_NORMAL: tgt_s[TGT_NORMAL] = 1'b1;
                BRAM_SELECT_STM:    tgt_s[TGT_STM]    = 1'b1;
                default:            tgt_s             = '0;
            endcase
        end else begin
            tgt_s = '0;
        end
    end

    // Stage 1: capture the write and update snooped segment/page registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_tgt_r    <= '0;
            s1_addr_r   <= 14'h0000;
            s1_din_r    <= 16'h0000;
            mod_seg_r   <= 1'b0;
            stm_seg_r   <= 1'b0;
            stm_page_r  <= '0;
            duty_page_r <= '0;
        end else begin
            s1_tgt_r  <= tgt_s;
            s1_addr_r <= ADDR[13:0];
            s1_din_r  <= DIN;
            if (ctl_reg_wr_s && (ADDR[13:0] == ADDR_MOD_MEM_WR_SEGMENT)) begin
                mod_seg_r <= DIN[0];
            end
            if (ctl_reg_wr_s && (ADDR[13:0] == ADDR_STM_MEM_WR_SEGMENT)) begin
                stm_seg_r <= DIN[0];
            end
            if (ctl_reg_wr_s && (ADDR[13:0] == ADDR_STM_MEM_WR_PAGE)) begin
                stm_page_r <= DIN[STM_PAGE_WIDTH-1:0];
            end
            if (ctl_reg_wr_s && (ADDR[13:0] == ADDR_DUTY_TABLE_WR_PAGE)) begin
                duty_page_r <= DIN[DUTY_PAGE_WIDTH-1:0];
            end
        end
    end

    // Stage 2: pulse the target strobe and form its full address; address
    // and data of idle targets hold their last value
    always_ff @(posedge CLK) begin
        if (RST) begin
            ctl_we_r      <= 1'b0;
            ctl_addr_r    <= 14'h0000;
            ctl_dout_r    <= 16'h0000;
            duty_we_r     <= 1'b0;
            duty_addr_r   <= '0;
            duty_dout_r   <= 16'h0000;
            mod_we_r      <= 1'b0;
            mod_addr_r    <= 15'h0000;
            mod_dout_r    <= 16'h0000;
            normal_we_r   <= 1'b0;
            normal_addr_r <= 14'h0000;
            normal_dout_r <= 16'h0000;
            stm_we_r      <= 1'b0;
            stm_addr_r    <= '0;
            stm_dout_r    <= 16'h0000;
        end else begin
            ctl_we_r    <= s1_tgt_r[TGT_CTL];
            duty_we_r   <= s1_tgt_r[TGT_DUTY];
            mod_we_r    <= s1_tgt_r[TGT_MOD];
            normal_we_r <= s1_tgt_r[TGT_NORMAL];
            stm_we_r    <= s1_tgt_r[TGT_STM];
            if (s1_tgt_r[TGT_CTL]) begin
                ctl_addr_r <= s1_addr_r;
                ctl_dout_r <= s1_din_r;
            end
            if (s1_tgt_r[TGT_DUTY]) begin
                duty_addr_r <= {duty_page_r, s1_addr_r[12:0]};
                duty_dout_r <= s1_din_r;
            end
            if (s1_tgt_r[TGT_MOD]) begin
                mod_addr_r <= {mod_seg_r, s1_addr_r};
                mod_dout_r <= s1_din_r;
            end
            if (s1_tgt_r[TGT_NORMAL]) begin
                normal_addr_r <= s1_addr_r;
                normal_dout_r <= s1_din_r;
            end
            if (s1_tgt_r[TGT_STM]) begin
                stm_addr_r <= {stm_seg_r, stm_page_r, s1_addr_r};
                stm_dout_r <= s1_din_r;
            end
        end
    end

    assign CTL_WE      = ctl_we_r;
    assign CTL_ADDR    = ctl_addr_r;
    assign CTL_DOUT    = ctl_dout_r;
    assign DUTY_WE     = duty_we_r;
    assign DUTY_ADDR   = duty_addr_r;
    assign DUTY_DOUT   = duty_dout_r;
    assign MOD_WE      = mod_we_r;
    assign MOD_ADDR    = mod_addr_r;
    assign MOD_DOUT    = mod_dout_r;
    assign NORMAL_WE   = normal_we_r;
    assign NORMAL_ADDR = normal_addr_r;
    assign NORMAL_DOUT = normal_dout_r;
    assign STM_WE      = stm_we_r;
    assign STM_ADDR    = stm_addr_r;
    assign STM_DOUT    = stm_dout_r;
    assign MOD_SEG     = mod_seg_r;
    assign STM_SEG     = stm_seg_r;
    assign STM_PAGE    = stm_page_r;
    assign DUTY_PAGE   = duty_page_r;

endmodule

// File: doc/mem_wr_router.md
# mem_wr_router

Routes single-cycle CPU bus writes to the four BRAM targets (controller, modulation, normal, STM) and forms their full write addresses. It sits directly behind the CPU bus synchronizer and in front of the controller register file, modulation memory, normal-gain memory and STM memory. It snoops controller writes to the segment/page registers, so modulation, STM and duty-table writes are steered into the correct segment/page without CPU help.

## Interface
Parameters:
- STM_PAGE_WIDTH, 5: width of the STM write-page register; STM address width = 1 + STM_PAGE_WIDTH + 14.
- DUTY_PAGE_WIDTH, 2: width of the duty-table write-page register.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- WE  in  1  write strobe, one cycle per write, already synchronous to CLK.
- ADDR  in  16  [15:14] BRAM select, [13:0] word address.
- DIN  in  16  write data.
- CTL_WE / CTL_ADDR[13:0] / CTL_DOUT[15:0]  out  controller register write; excludes the duty-table region.
- DUTY_WE / DUTY_ADDR[DUTY_PAGE_WIDTH+12:0] / DUTY_DOUT[15:0]  out  duty-table write.
- MOD_WE / MOD_ADDR[14:0] / MOD_DOUT[15:0]  out  modulation write, {segment, addr}.
- NORMAL_WE / NORMAL_ADDR[13:0] / NORMAL_DOUT[15:0]  out  normal-gain write.
- STM_WE / STM_ADDR[STM_PAGE_WIDTH+14:0] / STM_DOUT[15:0]  out  STM write, {segment, page, addr}.
- MOD_SEG, STM_SEG  out  1  current write segments.
- STM_PAGE  out  STM_PAGE_WIDTH  current STM write page.
- DUTY_PAGE  out  DUTY_PAGE_WIDTH  current duty-table write page.

## Operation
- Target decode on ADDR[15:14]: 0 controller, 1 modulation, 2 normal, 3 STM. Constants are BRAM_SELECT_* from the shared params package.
- Controller writes with ADDR[13]=1 go to the duty table: DUTY_ADDR = {DUTY_PAGE, ADDR[12:0]}. CTL_WE stays low for these writes.
- Snooped controller writes with ADDR[13]=0:
  - 0x020 (ADDR_MOD_MEM_WR_SEGMENT): MOD_SEG <= DIN[0].
  - 0x050 (ADDR_STM_MEM_WR_SEGMENT): STM_SEG <= DIN[0].
  - 0x058 (ADDR_STM_MEM_WR_PAGE): STM_PAGE <= DIN[STM_PAGE_WIDTH-1:0].
  - 0x060 (ADDR_DUTY_TABLE_WR_PAGE): DUTY_PAGE <= DIN[DUTY_PAGE_WIDTH-1:0].
- Snooped writes are still forwarded on CTL_* so the register file holds a readable copy.
- Upper DIN bits beyond each register width are ignored.
- Exactly one *_WE is asserted per input write; never more than one in the same cycle.

## Timing
- Two-stage pipeline:
  - Stage 1 registers WE/ADDR/DIN and the decoded one-hot target.
  - Stage 2 forms the target address and drives *_WE, *_ADDR, *_DOUT.
  - Latency from WE to *_WE is 2 cycles; throughput is one write per cycle.
- Segment/page registers update in stage 1 (1 cycle after WE).
- Hazard rule: a data write issued in the cycle immediately after a page/segment write uses the new value. Stage-2 address formation reads the registers, which are already updated, so no extra bypass is needed. Verification must prove this back-to-back case.
- Reset values: all *_WE 0, all *_ADDR/*_DOUT 0, MOD_SEG 0, STM_SEG 0, STM_PAGE 0, DUTY_PAGE 0.
- Reset mid-operation: writes in flight in either stage are dropped, with no *_WE pulse after RST. Reset dominates a simultaneous WE.
- STM_PAGE has no wrap logic; it holds exactly what was written, truncated to width.
- Output addresses and data hold their last value when *_WE is low. Consumers qualify only on *_WE.

## Structure
- Extend the params package:
  - Add typedef `bram_sel_t` (2-bit enum) for the four targets.
  - Add ADDR_DUTY_TABLE_REGION_BIT = 13.
  - Uncomment/define the segment and page addresses listed above.
- No STM_PAGE_WIDTH default constant is needed in the package; it stays a module parameter.
- Single module, no sub-module. The snoop register bank is small enough to stay inline.

## Test plan
- Reset then write ADDR=0x4005, DIN=0x1234 -> 2 cycles later MOD_WE=1, MOD_ADDR=0x0005, MOD_DOUT=0x1234; all other WE stay 0.
- Write 0x0020←1, then next cycle 0x4010←0xAA -> MOD_SEG=1, MOD_ADDR=0x4010.
- Write 0x0058←0x13, 0x0050←1, then next cycle 0xC003←0x55 -> STM_ADDR={1, 5'h13, 14'h0003}, STM_WE pulse of exactly 1 cycle.
- Write 0x0060←2, then 0x2100←0x7 -> DUTY_WE=1, DUTY_ADDR={2'b10, 13'h0100}, CTL_WE=0. Write 0x0060 itself -> CTL_WE=1, CTL_ADDR=0x060.
- Continuous writes every cycle alternating targets 0/1/2/3 for 64 cycles -> 64 output pulses in order, one-hot, 2-cycle latency each.
- Assert RST while two writes are in the pipeline -> no *_WE pulse follows; segment/page registers read 0 after reset.
